// File: rtl/rsa_modexp_decryptor.sv
// Modular exponentiation C^d mod n using right-to-left square-and-multiply over two parallel Blakley multipliers.
// Optional macro RSA_EARLY_EXIT_EN: finish as soon as the remaining exponent bits are all zero.
module rsa_modexp_decryptor #(
    parameter int DATA_W = 16,
    parameter int EXP_W  = 16,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_cipher,
    input  logic [DATA_W-1:0] in_mod,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_char,
    output logic [DATA_W-1:0] out_result,
    output logic              out_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, INIT, COMPUTE, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cipher_q, cipher_d;
    logic [DATA_W-1:0] mod_q, mod_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W:0]   accSq_q, accSq_d;
    logic [DATA_W:0]   accMul_q, accMul_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              outValid_q, outValid_d;
    logic [OUT_W-1:0]  outChar_q, outChar_d;
    logic [DATA_W-1:0] outResult_q, outResult_d;
    logic              outErr_q, outErr_d;

    logic              yBit;
    logic [DATA_W:0]   sqNext, mulNext;
    logic              expDone;
    logic              initSkip;

    // One Blakley step: acc = (2*acc + (ybit ? x : 0)) mod n, with acc and x already reduced below n.
    function automatic logic [DATA_W:0] blakleyStep(input logic [DATA_W:0] acc,
                                                    input logic [DATA_W-1:0] x,
                                                    input logic ybitIn,
                                                    input logic [DATA_W-1:0] n);
        logic [DATA_W:0] t;
        logic [DATA_W:0] nExt;
        nExt = {1'b0, n};
        t = acc << 1;
        if (t >= nExt) t = t - nExt;
        if (ybitIn) t = t + {1'b0, x};
        if (t >= nExt) t = t - nExt;
        return t;
    endfunction

    assign yBit    = |((base_q >> cnt_q) & DATA_W'(1));
    assign sqNext  = blakleyStep(accSq_q, base_q, yBit, mod_q);
    assign mulNext = blakleyStep(accMul_q, res_q, yBit, mod_q);

`ifdef RSA_EARLY_EXIT_EN
    assign expDone  = ((exp_q >> 1) == '0);
    assign initSkip = (exp_q == '0);
`else
    localparam int BW = $clog2(EXP_W + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(EXP_W - 1);
    logic [BW-1:0] bitCnt_q, bitCnt_d;

    assign bitCnt_d = (state_q == INIT) ? '0 :
                      (state_q == COMPUTE && cnt_q == '0) ? bitCnt_q + BW'(1) : bitCnt_q;
    assign expDone  = (bitCnt_q == BIT_LAST);
    assign initSkip = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) bitCnt_q <= '0;
        else       bitCnt_q <= bitCnt_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cipher_d    = cipher_q;
        mod_d       = mod_q;
        exp_d       = exp_q;
        res_d       = res_q;
        base_d      = base_q;
        accSq_d     = accSq_q;
        accMul_d    = accMul_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        outValid_d  = outValid_q;
        outChar_d   = outChar_q;
        outResult_d = outResult_q;
        outErr_d    = outErr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cipher_d = in_cipher;
                    mod_d    = in_mod;
                    exp_d    = in_exp;
                    err_d    = 1'b0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                accSq_d  = '0;
                accMul_d = '0;
                cnt_d    = CNT_TOP;
                if (mod_q < DATA_W'(2) || cipher_q >= mod_q) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = DONE;
                end else begin
                    res_d   = DATA_W'(1);
                    base_d  = cipher_q;
                    state_d = initSkip ? DONE : COMPUTE;
                end
            end
            COMPUTE: begin
                // The last step of a round commits the square always and the product only for a set exponent bit.
                if (cnt_q == '0) begin
                    base_d   = sqNext[DATA_W-1:0];
                    if (exp_q[0]) res_d = mulNext[DATA_W-1:0];
                    exp_d    = exp_q >> 1;
                    accSq_d  = '0;
                    accMul_d = '0;
                    cnt_d    = CNT_TOP;
                    if (expDone) state_d = DONE;
                end else begin
                    accSq_d  = sqNext;
                    accMul_d = mulNext;
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (!outValid_q) begin
                    outValid_d  = 1'b1;
                    outResult_d = res_q;
                    outChar_d   = res_q[OUT_W-1:0];
                    outErr_d    = err_q || ((res_q >> OUT_W) != '0);
                end else if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cipher_q    <= '0;
            mod_q       <= '0;
            exp_q       <= '0;
            res_q       <= '0;
            base_q      <= '0;
            accSq_q     <= '0;
            accMul_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            outValid_q  <= 1'b0;
            outChar_q   <= '0;
            outResult_q <= '0;
            outErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cipher_q    <= cipher_d;
            mod_q       <= mod_d;
            exp_q       <= exp_d;
            res_q       <= res_d;
            base_q      <= base_d;
            accSq_q     <= accSq_d;
            accMul_q    <= accMul_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            outValid_q  <= outValid_d;
            outChar_q   <= outChar_d;
            outResult_q <= outResult_d;
            outErr_q    <= outErr_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = outValid_q;
    assign out_char   = outChar_q;
    assign out_result = outResult_q;
    assign out_err    = outErr_q;

endmodule

// File: tb/tb_rsa_modexp_decryptor.sv
// Self-checking bench for rsa_modexp_decryptor: vector table, message stream, back-pressure and mid-run reset,
// with a scoreboard queue of expected results.
module tb_rsa_modexp_decryptor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_cipher = '0;
    logic [15:0] in_mod = '0;
    logic [15:0] in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_char;
    logic [15:0] out_result;
    logic        out_err;
    logic        busy;

    rsa_modexp_decryptor #(.DATA_W(16), .EXP_W(16), .OUT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cipher(in_cipher), .in_mod(in_mod), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_char(out_char), .out_result(out_result), .out_err(out_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] c;
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] res;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  chr;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   latency;
    bit   sawReady;

    // Plain modular exponentiation used as the reference model.
    function automatic int unsigned modPow(input int unsigned b, input int unsigned e, input int unsigned n);
        longint unsigned r = 1;
        longint unsigned x = b % n;
        for (int i = 0; i < 16; i++) begin
            if (((e >> i) & 1) != 0) r = (r * x) % n;
            x = (x * x) % n;
        end
        return int'(r % n);
    endfunction

    function automatic int expLatency(input logic [15:0] c, input logic [15:0] n, input logic [15:0] d);
        int bl;
        if (n < 16'd2 || c >= n) return 2;
        bl = 0;
        for (int i = 0; i < 16; i++) if (d[i]) bl = i + 1;
`ifdef RSA_EARLY_EXIT_EN
        return bl * 16 + 2;
`else
        return 16 * 16 + 2 + 0 * bl;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drive one request on a free slot and record the expected outcome.
    task automatic applyStimulus(input logic [15:0] c, input logic [15:0] n, input logic [15:0] d,
                                 input logic [15:0] expRes, input logic expErr);
        exp_t e;
        int guard = 0;
        while (!in_ready && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_req", 32'(in_ready), 32'd1);
        in_cipher = c;
        in_mod    = n;
        in_exp    = d;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_cipher = 16'($urandom);
        in_mod    = 16'($urandom);
        in_exp    = 16'($urandom);
        e.res = expRes;
        e.chr = expRes[7:0];
        e.err = expErr;
        e.lat = expLatency(c, n, d);
        sb.push_back(e);
    endtask

    task automatic waitOutput();
        latency  = 0;
        sawReady = 1'b0;
        while (!out_valid && latency < 600) begin
            if (in_ready) sawReady = 1'b1;
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("out_valid_seen", 32'(out_valid), 32'd1);
        if (!out_valid) begin
            pulseReset();
            return;
        end
        check("latency", 32'(latency), 32'(e.lat));
        check("out_result", 32'(out_result), 32'(e.res));
        check("out_char", 32'(out_char), 32'(e.chr));
        check("out_err", 32'(out_err), 32'(e.err));
        check("in_ready_low_while_busy", 32'(sawReady), 32'd0);
    endtask

    task automatic finishTransfer();
        out_ready = 1'b1;
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("out_valid_after_xfer", 32'(out_valid), 32'd0);
        check("in_ready_after_xfer", 32'(in_ready), 32'd1);
    endtask

    vec_t  vecs[7];
    string msg;
    logic [15:0] ct;
    logic [15:0] m;

    initial begin
        vecs[0] = '{c: 16'd2790, n: 16'd3233, d: 16'd2753, res: 16'd65,   err: 1'b0};
        vecs[1] = '{c: 16'd0,    n: 16'd1,    d: 16'd2753, res: 16'd0,    err: 1'b1};
        vecs[2] = '{c: 16'd3233, n: 16'd3233, d: 16'd2753, res: 16'd0,    err: 1'b1};
        vecs[3] = '{c: 16'd3000, n: 16'd3233, d: 16'd1,    res: 16'd3000, err: 1'b1};
        vecs[4] = '{c: 16'd5,    n: 16'd3233, d: 16'd0,    res: 16'd1,    err: 1'b0};
        vecs[5] = '{c: 16'd0,    n: 16'd3233, d: 16'd2753, res: 16'd0,    err: 1'b0};
        vecs[6] = '{c: 16'd65,   n: 16'd3233, d: 16'd17,   res: 16'd2790, err: 1'b1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_char", 32'(out_char), 32'd0);
        check("reset_out_result", 32'(out_result), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].c, vecs[i].n, vecs[i].d, vecs[i].res, vecs[i].err);
            waitOutput();
            checkOutput();
            finishTransfer();
        end

        // Back-to-back message stream encrypted with e=17.
        msg = "HELLO RSA WORLD 2024";
        for (int i = 0; i < msg.len(); i++) begin
            m  = 16'(msg[i]);
            ct = 16'(modPow(32'(m), 32'd17, 32'd3233));
            applyStimulus(ct, 16'd3233, 16'd2753, m, 1'b0);
            waitOutput();
            checkOutput();
            finishTransfer();
        end

        // Back-pressure: hold the result for 50 cycles while a competing request is offered.
        out_ready = 1'b0;
        applyStimulus(16'd2790, 16'd3233, 16'd2753, 16'd65, 1'b0);
        waitOutput();
        checkOutput();
        for (int k = 0; k < 50; k++) begin
            in_valid  = 1'b1;
            in_cipher = 16'($urandom_range(0, 3232));
            in_mod    = 16'd3233;
            in_exp    = 16'd17;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_result", 32'(out_result), 32'd65);
            check("bp_out_char", 32'(out_char), 32'h41);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        finishTransfer();
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_no_extra_busy", 32'(busy), 32'd0);
            check("bp_no_extra_valid", 32'(out_valid), 32'd0);
        end

        // Reset 100 cycles into a computation aborts it silently.
        applyStimulus(16'd1234, 16'd3233, 16'd2753, 16'd0, 1'b0);
        repeat (99) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        sb.delete();
        applyStimulus(16'd2790, 16'd3233, 16'd2753, 16'd65, 1'b0);
        waitOutput();
        checkOutput();
        finishTransfer();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "[TB] global timeout");
    end

endmodule
